// File: rtl/ets_phase_stepper_if.sv
// rtl/ets_phase_stepper_if.sv - signal bundle for the ETS phase stepper
//
// Groups the target handshake, the DCM phase-shift handshake and the status
// outputs of ets_phase_stepper.
//   master : the side that offers targets and models the DCM
//   slave  : the stepper itself
// The names match the stepper's port names one for one.
interface ets_phase_stepper_if;
  logic [7:0] target;
  logic       target_valid;
  logic       target_ready;
  logic       dcm_lock;
  logic       psen;
  logic       psincdec;
  logic       psdone;
  logic [7:0] position;
  logic       settled;
  logic       timeout_err;

  modport master (
    output target, target_valid, dcm_lock, psdone,
    input  target_ready, psen, psincdec, position, settled, timeout_err
  );

  modport slave (
    input  target, target_valid, dcm_lock, psdone,
    output target_ready, psen, psincdec, position, settled, timeout_err
  );
endinterface

// File: rtl/ets_phase_stepper.sv
// rtl/ets_phase_stepper.sv - walks a DCM phase shifter one step at a time to a requested position
//
// Ports:
//   ref_clk       sole clock (DCM phase-shift domain)
//   reset_n       synchronous active-low reset
//   target        requested phase position, steps above calibration
//   target_valid  target offer; taken when target_ready is high
//   target_ready  high only while idle
//   dcm_lock      DCM locked; a drop means the DCM returned to calibration phase
//   psen          one-cycle phase-shift enable pulse to the DCM
//   psincdec      step direction, 1 = increment
//   psdone        DCM completion pulse for the last psen
//   position      current phase position in steps
//   settled       position equals the last accepted target
//   timeout_err   sticky psdone timeout flag
// Optional feature: define ETS_PHASE_TIMEOUT_EN to abort into FAULT when
// psdone does not arrive within TIMEOUT_CYCLES cycles; otherwise WAIT waits
// forever and timeout_err is tied low.
module ets_phase_stepper #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       ref_clk,
  input  logic       reset_n,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic       dcm_lock,
  output logic       psen,
  output logic       psincdec,
  input  logic       psdone,
  output logic [7:0] position,
  output logic       settled,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_PULSE, S_WAIT, S_FAULT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_target, w_target_nxt;
  logic [7:0] r_position, w_position_nxt;
  logic [7:0] w_pos_stepped;
  logic       r_psen, w_psen_nxt;
  logic       r_psincdec, w_psincdec_nxt;
  logic       r_settled, w_settled_nxt;
  logic       r_ready, w_ready_nxt;

`ifdef ETS_PHASE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_timeout_err, w_timeout_err_nxt;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_position_nxt = r_position;
    w_psincdec_nxt = r_psincdec;
    w_settled_nxt  = r_settled;
`ifdef ETS_PHASE_TIMEOUT_EN
    w_count_nxt       = r_count;
    w_timeout_err_nxt = r_timeout_err;
`endif

    // Completed step never moves past the target, so position cannot wrap.
    w_pos_stepped = r_position;
    if (r_psincdec && (r_position < r_target))
      w_pos_stepped = r_position + 8'd1;
    else if (!r_psincdec && (r_position > r_target))
      w_pos_stepped = r_position - 8'd1;

    case (r_state)
      S_IDLE: begin
        if (!dcm_lock) begin
          w_position_nxt = 8'd0;
          w_settled_nxt  = 1'b0;
        end
        if (target_valid) begin
          w_target_nxt  = target;
          w_settled_nxt = 1'b0;
          w_state_nxt   = S_STEP;
        end
      end
      S_STEP: begin
        // Lock loss outranks the arrival check: the DCM is back at calibration.
        if (!dcm_lock) begin
          w_position_nxt = 8'd0;
          w_settled_nxt  = 1'b0;
        end else if (r_position == r_target) begin
          w_settled_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_psincdec_nxt = (r_target > r_position);
          w_state_nxt    = S_PULSE;
        end
      end
      S_PULSE, S_WAIT: begin
        // psdone in the PULSE cycle itself completes the step.
        if (!dcm_lock) begin
          w_position_nxt = 8'd0;
          w_settled_nxt  = 1'b0;
          w_state_nxt    = S_STEP;
        end else if (psdone) begin
          w_position_nxt = w_pos_stepped;
          w_state_nxt    = S_STEP;
        end else if (r_state == S_PULSE) begin
          w_state_nxt = S_WAIT;
`ifdef ETS_PHASE_TIMEOUT_EN
          w_count_nxt = '0;
`endif
        end else begin
`ifdef ETS_PHASE_TIMEOUT_EN
          if (r_count == C_LAST) begin
            w_timeout_err_nxt = 1'b1;
            w_state_nxt       = S_FAULT;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
`endif
        end
      end
      S_FAULT: begin
        // Held until reset_n.
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_psen_nxt  = (w_state_nxt == S_PULSE);
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge ref_clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_target   <= 8'd0;
      r_position <= 8'd0;
      r_psen     <= 1'b0;
      r_psincdec <= 1'b0;
      r_settled  <= 1'b1;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_position <= w_position_nxt;
      r_psen     <= w_psen_nxt;
      r_psincdec <= w_psincdec_nxt;
      r_settled  <= w_settled_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

`ifdef ETS_PHASE_TIMEOUT_EN
  always_ff @(posedge ref_clk) begin
    if (!reset_n) begin
      r_count       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_count       <= w_count_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign target_ready = r_ready;
  assign psen         = r_psen;
  assign psincdec     = r_psincdec;
  assign position     = r_position;
  assign settled      = r_settled;

endmodule

// File: tb/tb_ets_phase_stepper.sv
// tb/tb_ets_phase_stepper.sv - self-checking bench for ets_phase_stepper
module tb_ets_phase_stepper;
  localparam int TMO = 16;

  logic ref_clk = 1'b0;
  logic reset_n = 1'b0;
  ets_phase_stepper_if bus();

  always #5 ref_clk = ~ref_clk;

  ets_phase_stepper #(.TIMEOUT_CYCLES(TMO)) dut (
    .ref_clk      (ref_clk),
    .reset_n      (reset_n),
    .target       (bus.target),
    .target_valid (bus.target_valid),
    .target_ready (bus.target_ready),
    .dcm_lock     (bus.dcm_lock),
    .psen         (bus.psen),
    .psincdec     (bus.psincdec),
    .psdone       (bus.psdone),
    .position     (bus.position),
    .settled      (bus.settled),
    .timeout_err  (bus.timeout_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Model: position follows completed steps, lock loss returns to 0.
  int m_pos = 0, m_tgt = 0;
  bit m_pend = 0, m_pdir = 0;
  // DCM model: psdone dly cycles after the psen cycle (0 = same cycle).
  int dly = 10;
  bit hold = 0;
  int cd = 0;
  int n_inc = 0, n_dec = 0;

  always @(negedge ref_clk) begin
    if (reset_n) begin
      check("position", bus.position, m_pos);
      if (bus.psen) begin
        check("psen_dir", bus.psincdec, (m_tgt > m_pos) ? 1 : 0);
        check("psen_while_pending", m_pend, 0);
        if (bus.psincdec) n_inc++;
        else n_dec++;
      end
      if (bus.settled) check("settled_at_target", bus.position, m_tgt);
`ifndef ETS_PHASE_TIMEOUT_EN
      check("timeout_err_tied", bus.timeout_err, 0);
`endif
    end
    if (!reset_n || !bus.dcm_lock) begin
      cd = 0;
      bus.psdone = 1'b0;
    end else if (bus.psen && !hold) begin
      if (dly == 0) bus.psdone = 1'b1;
      else begin
        cd = dly;
        bus.psdone = 1'b0;
      end
    end else if (cd > 0) begin
      cd--;
      bus.psdone = (cd == 0);
    end else begin
      bus.psdone = 1'b0;
    end
    if (!reset_n) begin
      m_pos = 0; m_tgt = 0; m_pend = 0;
    end else begin
      if (bus.target_valid && bus.target_ready) m_tgt = bus.target;
      if (!bus.dcm_lock) begin
        m_pos = 0; m_pend = 0;
      end else begin
        if (bus.psen) begin
          m_pend = 1; m_pdir = bus.psincdec;
        end
        if (m_pend && bus.psdone) begin
          m_pos = m_pdir ? m_pos + 1 : m_pos - 1;
          m_pend = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ref_clk);
    #2;
  endtask

  // Offers tgt, returns edges from the accept edge (counted as 1) to the
  // edge after which settled is first seen high.
  task automatic go(input int tgt, output int lat);
    tick();
    n_inc = 0; n_dec = 0;
    bus.target = tgt[7:0];
    bus.target_valid = 1'b1;
    @(posedge ref_clk);
    #2 bus.target_valid = 1'b0;
    lat = 1;
    while (lat < 400) begin
      @(negedge ref_clk);
      if (bus.settled) break;
      @(posedge ref_clk);
      lat++;
    end
    check("settle_in_bound", (lat < 400) ? 1 : 0, 1);
  endtask

  task automatic wait_settled(input int bound);
    int k;
    k = 0;
    while (!(bus.settled && bus.target_ready) && k < bound) begin
      tick();
      k++;
    end
    check("wait_settled_bound", (k < bound) ? 1 : 0, 1);
  endtask

  initial begin
    int lat;
    int k;
    bus.target = 8'd0;
    bus.target_valid = 1'b0;
    bus.dcm_lock = 1'b1;
    bus.psdone = 1'b0;
    repeat (3) @(posedge ref_clk);
    #2 reset_n = 1'b1;

    check("rst_ready", bus.target_ready, 1);
    check("rst_settled", bus.settled, 1);
    check("rst_position", bus.position, 0);
    check("rst_psen", bus.psen, 0);
    check("rst_psincdec", bus.psincdec, 0);
    check("rst_timeout_err", bus.timeout_err, 0);

    // 0 -> 5, psdone 10 cycles after psen
    go(5, lat);
    check("up5_inc", n_inc, 5);
    check("up5_dec", n_dec, 0);
    check("up5_pos", bus.position, 5);
    check("up5_settled", bus.settled, 1);

    // 5 -> 2
    go(2, lat);
    check("dn2_dec", n_dec, 3);
    check("dn2_inc", n_inc, 0);
    check("dn2_pos", bus.position, 2);

    // 2 -> 7, then 7 -> 7: accept edge + one STEP edge
    go(7, lat);
    check("up7_inc", n_inc, 5);
    go(7, lat);
    check("eq7_pulses", n_inc + n_dec, 0);
    check("eq7_latency", lat, 2);
    check("eq7_pos", bus.position, 7);

    // single step: accept, STEP->PULSE, then psdone sampled 11 edges after
    // the psen edge, then STEP->IDLE: 1 + 1 + 11 + 1 = 14
    go(8, lat);
    check("one_step_latency", lat, 14);
    check("one_step_pulses", n_inc, 1);

    // lock loss in IDLE
    tick();
    bus.dcm_lock = 1'b0;
    tick();
    bus.dcm_lock = 1'b1;
    check("idle_unlock_pos", bus.position, 0);
    check("idle_unlock_settled", bus.settled, 0);
    check("idle_unlock_ready", bus.target_ready, 1);

    // lock loss during WAIT of step 3 toward 6
    tick();
    n_inc = 0; n_dec = 0;
    bus.target = 8'd6;
    bus.target_valid = 1'b1;
    tick();
    bus.target_valid = 1'b0;
    k = 0;
    while (n_inc < 3 && k < 200) begin
      tick();
      k++;
    end
    check("third_pulse_seen", n_inc, 3);
    tick();
    tick();
    check("pre_drop_pos", bus.position, 2);
    bus.dcm_lock = 1'b0;
    tick();
    check("drop_pos", bus.position, 0);
    check("drop_settled", bus.settled, 0);
    tick();
    tick();
    check("unlocked_no_pulse", n_inc, 3);
    bus.dcm_lock = 1'b1;
    n_inc = 0;
    wait_settled(300);
    check("relock_inc", n_inc, 6);
    check("relock_pos", bus.position, 6);

    // target 9 held valid while stepping toward 4
    dly = 3;
    tick();
    n_inc = 0; n_dec = 0;
    bus.target = 8'd4;
    bus.target_valid = 1'b1;
    tick();
    bus.target = 8'd9;
    k = 0;
    while (!(bus.settled && bus.position == 8'd9) && k < 300) begin
      tick();
      k++;
    end
    bus.target_valid = 1'b0;
    check("held_bound", (k < 300) ? 1 : 0, 1);
    check("held_dec", n_dec, 2);
    check("held_inc", n_inc, 5);
    check("held_pos", bus.position, 9);
    wait_settled(100);

    // psdone in the PULSE cycle
    dly = 0;
    go(10, lat);
    check("fast_done_latency", lat, 4);
    check("fast_done_pulses", n_inc, 1);
    check("fast_done_pos", bus.position, 10);

    // reset mid-step
    dly = 10;
    tick();
    bus.target = 8'd50;
    bus.target_valid = 1'b1;
    tick();
    bus.target_valid = 1'b0;
    repeat (15) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_pos", bus.position, 0);
    check("midrst_ready", bus.target_ready, 1);
    check("midrst_settled", bus.settled, 1);
    check("midrst_psen", bus.psen, 0);
    n_inc = 0; n_dec = 0;
    repeat (20) tick();
    check("midrst_quiet", n_inc + n_dec, 0);

    // psdone withheld
    hold = 1;
    tick();
    n_inc = 0;
    bus.target = 8'd3;
    bus.target_valid = 1'b1;
    tick();
    bus.target_valid = 1'b0;
`ifdef ETS_PHASE_TIMEOUT_EN
    // WAIT occupies edges 2..17 after accept; FAULT after edge 18
    repeat (17) tick();
    check("tmo_not_yet", bus.timeout_err, 0);
    tick();
    check("tmo_err", bus.timeout_err, 1);
    check("tmo_ready", bus.target_ready, 0);
    repeat (30) tick();
    check("tmo_one_pulse", n_inc, 1);
    check("tmo_sticky", bus.timeout_err, 1);
    check("tmo_ready_held", bus.target_ready, 0);
`else
    repeat (40) tick();
    check("nowait_ready", bus.target_ready, 0);
    check("nowait_one_pulse", n_inc, 1);
    check("nowait_err", bus.timeout_err, 0);
`endif
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    hold = 0;
    check("final_rst_err", bus.timeout_err, 0);
    check("final_rst_ready", bus.target_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
